fixed_to_float_12: RTL and testbench

- Pipelined encoder from signed two's-complement fixed point to the 12-bit float format consumed by the float arithmetic blocks.
- Float format: sign[11], exponent[10:6] (bias 15), mantissa[5:0] with hidden leading one. All-zero word = zero.
- Sits at the front of the datapath and turns raw fixed-point samples/weights into operands for the float adders/multipliers.
- Valid/ready streaming interface with full-pipeline backpressure.

---
 rtl/fixed_to_float_12_if.sv | 28 ++
 rtl/fixed_to_float_12.sv | 108 ++++++++++
 tb/tb_fixed_to_float_12.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fixed_to_float_12_if.sv
// Valid/ready stream bundle for the fixed-point to float12 encoder.
// Signal names are seen from the encoder: *_i flow into it, *_o flow out of it.
interface fixed_to_float_12_if;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [11:0] data_o;
    logic        valid_o;
    logic        ready_i;

    modport slave (
        input  data_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output valid_o
    );

    modport master (
        output data_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  valid_o
    );
endinterface

// File: rtl/fixed_to_float_12.sv
// Three-stage encoder: signed fixed point (FRAC_BITS fractional bits) to float12
// {sign, exp[4:0] bias 15, man[5:0] hidden one}; the whole pipe stalls as one unit.
module fixed_to_float_12 #(
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    fixed_to_float_12_if.slave   bus
);

    localparam int unsigned IN_W   = 16;
    localparam int unsigned MAG_W  = 17;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MAN_W  = 6;
    localparam int unsigned OUT_W  = 12;
    localparam int unsigned BIAS   = 15;

    logic               w_adv;

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic [MAG_W-1:0]   r_s1_mag;

    logic               r_s2_valid;
    logic               r_s2_sign;
    logic               r_s2_zero;
    logic [EXP_W-1:0]   r_s2_exp;
    logic [MAN_W:0]     r_s2_frac;

    logic               r_valid_o;
    logic [OUT_W-1:0]   r_data_o;

    logic [MAG_W-1:0]   w_mag;
    logic [POS_W-1:0]   w_pos;
    logic [MAG_W-1:0]   w_norm;
    logic [EXP_W-1:0]   w_exp;
    logic [MAN_W:0]     w_man_sum;
    logic [EXP_W-1:0]   w_exp_rnd;
    logic               w_unused;

    assign w_adv       = ~r_valid_o | bus.ready_i;
    assign bus.ready_o = w_adv;
    assign bus.valid_o = r_valid_o;
    assign bus.data_o  = r_data_o;

    // Magnitude: 0x8000 yields 32768, which still fits in 17 bits.
    assign w_mag = bus.data_i[IN_W-1] ? (MAG_W'(~bus.data_i) + MAG_W'(1))
                                      : MAG_W'(bus.data_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= bus.valid_i;
            r_s1_sign  <= bus.data_i[IN_W-1];
            r_s1_mag   <= w_mag;
        end
    end

    // Leading-one detect; highest set bit wins.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (r_s1_mag[i]) w_pos = POS_W'(i);
        end
    end

    assign w_norm = r_s1_mag << (EXP_W'(16) - EXP_W'(w_pos));
    assign w_exp  = EXP_W'(6'(BIAS) + 6'(w_pos) - 6'(FRAC_BITS));

    // Only the mantissa field and guard bit survive into stage 3.
    assign w_unused = ^{w_norm[MAG_W-1], w_norm[8:0]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_frac  <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_zero  <= (r_s1_mag == '0);
            r_s2_exp   <= w_exp;
            r_s2_frac  <= w_norm[15:9];
        end
    end

    // Round half up on the magnitude; a carry out of the mantissa bumps the exponent.
    assign w_man_sum = {1'b0, r_s2_frac[MAN_W:1]} + (MAN_W+1)'(r_s2_frac[0]);
    assign w_exp_rnd = r_s2_exp + EXP_W'(w_man_sum[MAN_W]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
        end else if (w_adv) begin
            r_valid_o <= r_s2_valid;
            r_data_o  <= r_s2_zero ? '0
                                   : {r_s2_sign, w_exp_rnd, w_man_sum[MAN_W-1:0]};
        end
    end

endmodule

// File: tb/tb_fixed_to_float_12.sv
// Directed bench for fixed_to_float_12 with a scoreboard per instance (FRAC_BITS 8 and 0).
module tb_fixed_to_float_12;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [11:0] q8[$];
    logic [11:0] q0[$];

    fixed_to_float_12_if bus8();
    fixed_to_float_12_if bus0();

    fixed_to_float_12 #(.FRAC_BITS(8)) dut8 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus8));
    fixed_to_float_12 #(.FRAC_BITS(0)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Present one item and hold it until accepted; valid_i stays high afterwards.
    task automatic send(input int sel, input logic [15:0] d, input logic [11:0] e);
        logic rdy;
        if (sel == 0) begin bus8.data_i = d; bus8.valid_i = 1'b1; end
        else          begin bus0.data_i = d; bus0.valid_i = 1'b1; end
        rdy = (sel == 0) ? bus8.ready_o : bus0.ready_o;
        for (int k = 0; k < 50 && !rdy; k++) begin
            @(posedge clk); #1;
            rdy = (sel == 0) ? bus8.ready_o : bus0.ready_o;
        end
        if (!rdy) begin
            checks++; errors++;
            $error("FAIL send_timeout got ready_o 0 exp 1");
        end else begin
            if (sel == 0) q8.push_back(e); else q0.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        bus8.valid_i = 1'b0;
        bus0.valid_i = 1'b0;
    endtask

    task automatic send_lat(input logic [15:0] d, input logic [11:0] e);
        send(0, d, e);
        idle();
        chk("lat_c0", 16'(bus8.valid_o), 16'd0);
        @(posedge clk); #1;
        chk("lat_c1", 16'(bus8.valid_o), 16'd0);
        @(posedge clk); #1;
        chk("lat_c2", 16'(bus8.valid_o), 16'd1);
        @(posedge clk); #1;
    endtask

    // Output transfers are predicted from values that are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus8.valid_o && bus8.ready_i) begin
                if (q8.size() == 0) begin
                    checks++;
                    assert (q8.size() != 0) else begin
                        errors++;
                        $error("FAIL spurious8 got %h exp none", bus8.data_o);
                    end
                end else begin
                    chk("out8", 16'(bus8.data_o), 16'(q8.pop_front()));
                end
            end
            if (bus0.valid_o && bus0.ready_i) begin
                if (q0.size() == 0) begin
                    checks++;
                    assert (q0.size() != 0) else begin
                        errors++;
                        $error("FAIL spurious0 got %h exp none", bus0.data_o);
                    end
                end else begin
                    chk("out0", 16'(bus0.data_o), 16'(q0.pop_front()));
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus8.data_i = '0; bus8.valid_i = 1'b0; bus8.ready_i = 1'b1;
        bus0.data_i = '0; bus0.valid_i = 1'b0; bus0.ready_i = 1'b1;
        #12;
        chk("rst_valid", 16'(bus8.valid_o), 16'd0);
        chk("rst_data",  16'(bus8.data_o),  16'h000);
        chk("rst_ready", 16'(bus8.ready_o), 16'd1);
        chk("rst_valid0", 16'(bus0.valid_o), 16'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        send_lat(16'h0100, 12'h3C0);
        send_lat(16'hFE80, 12'hBE0);
        send_lat(16'h0000, 12'h000);

        // Back-to-back extremes and rounding cases.
        send(0, 16'h8000, 12'hD80);
        send(0, 16'h0001, 12'h1C0);
        send(0, 16'h7FFF, 12'h580);
        send(0, 16'h01FF, 12'h400);
        send(0, 16'h0101, 12'h3C0);
        send(0, 16'h0102, 12'h3C1);
        send(0, 16'hFF00, 12'hBC0);
        idle();

        send(1, 16'h0001, 12'h3C0);
        send(1, 16'h4000, 12'h740);
        send(1, 16'hFFFF, 12'hBC0);
        idle();
        repeat (5) @(posedge clk);
        #1;

        // Backpressure: stall once the first result is at the output.
        send(0, 16'h0100, 12'h3C0);
        send(0, 16'h0200, 12'h400);
        send(0, 16'h0300, 12'h420);
        idle();
        bus8.ready_i = 1'b0;
        chk("bp_valid", 16'(bus8.valid_o), 16'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("bp_ready", 16'(bus8.ready_o), 16'd0);
            chk("bp_hold",  16'(bus8.data_o),  16'h3C0);
        end
        bus8.ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_drain", 16'(q8.size()), 16'd0);

        // Asynchronous reset with two items in flight.
        send(0, 16'h0100, 12'h3C0);
        send(0, 16'h0200, 12'h400);
        idle();
        @(posedge clk); #2;
        chk("pre_rst_valid", 16'(bus8.valid_o), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(bus8.valid_o), 16'd0);
        chk("mid_rst_data",  16'(bus8.data_o),  16'h000);
        chk("mid_rst_ready", 16'(bus8.ready_o), 16'd1);
        q8.delete();
        q0.delete();
        #20 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", 16'(bus8.valid_o), 16'd0);
        end

        send_lat(16'h0102, 12'h3C1);

        for (int c = 0; c < 200 && (q8.size() != 0 || q0.size() != 0); c++) begin
            @(posedge clk); #1;
        end
        chk("final_q8", 16'(q8.size()), 16'd0);
        chk("final_q0", 16'(q0.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
